// File: rtl/nrz_to_man_frame_enc.sv
// Manchester frame encoder: parallel words in over valid/ready, registered Manchester line out.
// Each frame is an optional alternating preamble followed by the data word, one half-bit per clk.
module nrz_to_man_frame_enc #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned PRE_BITS  = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              Man,
    output logic              Man_active,
    output logic              half_phase
);

    localparam int unsigned MaxBits = (PRE_BITS > DATA_W) ? PRE_BITS : DATA_W;
    localparam int unsigned CntW    = $clog2(MaxBits + 1);
    localparam logic [CntW-1:0] PreLast  = CntW'((PRE_BITS > 0) ? (PRE_BITS - 1) : 0);
    localparam logic [CntW-1:0] DataLast = CntW'(DATA_W - 1);

    typedef enum logic [1:0] {
        StIdle,
        StPre,
        StData
    } state_e;

    state_e            state_q, state_d;
    logic              half_q, half_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic              man_q, man_d;
    logic              active_q, active_d;
    logic              ready_q, ready_d;
    logic              accept;
    logic              data_bit;

    assign accept = tx_valid & ready_q;

    always_comb begin
        state_d = state_q;
        half_d  = half_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    sh_d    = tx_data;
                    half_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = (PRE_BITS > 0) ? StPre : StData;
                end
            end
            StPre: begin
                if (!half_q) begin
                    half_d = 1'b1;
                end else begin
                    half_d = 1'b0;
                    if (cnt_q == PreLast) begin
                        cnt_d   = '0;
                        state_d = StData;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StData: begin
                if (!half_q) begin
                    half_d = 1'b1;
                end else begin
                    half_d = 1'b0;
                    if (cnt_q == DataLast) begin
                        cnt_d = '0;
                        // Accept in the final half-bit chains the next word with no preamble.
                        if (accept) begin
                            sh_d = tx_data;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                        sh_d  = MSB_FIRST ? (sh_q << 1) : (sh_q >> 1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
                half_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the line is registered with no extra lag.
    assign data_bit = MSB_FIRST ? sh_d[DATA_W-1] : sh_d[0];

    always_comb begin
        man_d = 1'b0;
        unique case (state_d)
            StPre:   man_d = ~cnt_d[0] ^ half_d;
            StData:  man_d = data_bit ^ half_d;
            default: man_d = 1'b0;
        endcase
        active_d = (state_d != StIdle);
        ready_d  = (state_d == StIdle) ||
                   ((state_d == StData) && half_d && (cnt_d == DataLast));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            half_q   <= 1'b0;
            cnt_q    <= '0;
            sh_q     <= '0;
            man_q    <= 1'b0;
            active_q <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            half_q   <= half_d;
            cnt_q    <= cnt_d;
            sh_q     <= sh_d;
            man_q    <= man_d;
            active_q <= active_d;
            ready_q  <= ready_d;
        end
    end

    assign tx_ready   = ready_q;
    assign Man        = man_q;
    assign Man_active = active_q;
    assign half_phase = half_q;

endmodule

// File: tb/tb_nrz_to_man_frame_enc.sv
// Directed bench for nrz_to_man_frame_enc: default instance plus a PRE_BITS=0, LSB-first one.
module tb_nrz_to_man_frame_enc;

    logic       clk;
    logic       rst_n;
    logic [7:0] tx_data, tx_data0;
    logic       tx_valid, tx_valid0;
    logic       tx_ready, man, man_active, half_phase;
    logic       tx_ready0, man0, man_active0, half_phase0;

    int n_checks;
    int n_errors;

    nrz_to_man_frame_enc #(
        .DATA_W   (8),
        .PRE_BITS (4),
        .MSB_FIRST(1'b1)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .Man       (man),
        .Man_active(man_active),
        .half_phase(half_phase)
    );

    nrz_to_man_frame_enc #(
        .DATA_W   (8),
        .PRE_BITS (0),
        .MSB_FIRST(1'b0)
    ) u_dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .tx_data   (tx_data0),
        .tx_valid  (tx_valid0),
        .tx_ready  (tx_ready0),
        .Man       (man0),
        .Man_active(man_active0),
        .half_phase(half_phase0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cyc(input string tag, input int i, input logic e_man, input logic e_rdy,
                           input logic o_man, input logic o_act, input logic o_rdy,
                           input logic o_hp);
        check($sformatf("%s man[%0d]", tag, i), {31'd0, o_man}, {31'd0, e_man});
        check($sformatf("%s act[%0d]", tag, i), {31'd0, o_act}, 32'd1);
        check($sformatf("%s rdy[%0d]", tag, i), {31'd0, o_rdy}, {31'd0, e_rdy});
        check($sformatf("%s hp[%0d]", tag, i), {31'd0, o_hp}, i % 2);
    endtask

    task automatic chk_idle(input string tag);
        check({tag, " idle man"}, {31'd0, man}, 32'd0);
        check({tag, " idle act"}, {31'd0, man_active}, 32'd0);
        check({tag, " idle rdy"}, {31'd0, tx_ready}, 32'd1);
    endtask

    logic [63:0] exp_seq;
    logic [3:0]  pre_dec;
    logic [7:0]  data_dec;
    logic [7:0]  word;
    logic        bad_pair;
    logic        first_half;

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        tx_data   = 8'h00;
        tx_valid  = 1'b0;
        tx_data0  = 8'h00;
        tx_valid0 = 1'b0;

        // Power-on reset
        #12;
        check("por man", {31'd0, man}, 32'd0);
        check("por rdy", {31'd0, tx_ready}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("rel rdy before edge", {31'd0, tx_ready}, 32'd0);
        tick();
        chk_idle("por");

        // Single word 0xA5 from idle
        exp_seq = {40'd0, 8'b10011001, 16'h9966};
        tx_data = 8'hA5;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        for (int i = 0; i < 24; i++) begin
            chk_cyc("a5", i, exp_seq[23-i], i == 23, man, man_active, tx_ready, half_phase);
            tick();
        end
        chk_idle("a5");

        // Back-to-back 0xFF then 0x00, tx_valid held
        exp_seq = {24'd0, 8'b10011001, 16'hAAAA, 16'h5555};
        tx_data = 8'hFF;
        tx_valid = 1'b1;
        tick();
        tx_data = 8'h00;
        for (int i = 0; i < 40; i++) begin
            chk_cyc("b2b", i, exp_seq[39-i], (i == 23) || (i == 39),
                    man, man_active, tx_ready, half_phase);
            tick();
            if (i == 23) tx_valid = 1'b0;
        end
        chk_idle("b2b");

        // 0x81 with tx_data changed after accept and stray tx_valid pulses
        exp_seq = {40'd0, 8'b10011001, 16'h9556};
        tx_data = 8'h81;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        for (int i = 0; i < 24; i++) begin
            chk_cyc("hold", i, exp_seq[23-i], i == 23, man, man_active, tx_ready, half_phase);
            if (i == 0) tx_data = 8'h3C;
            tx_valid = (i == 5) || (i == 12) || (i == 13);
            tick();
        end
        tx_valid = 1'b0;
        chk_idle("hold");

        // No preamble, LSB first, word 0x01
        exp_seq = {48'd0, 16'h9555};
        check("np idle rdy", {31'd0, tx_ready0}, 32'd1);
        tx_data0 = 8'h01;
        tx_valid0 = 1'b1;
        tick();
        tx_valid0 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk_cyc("np", i, exp_seq[15-i], i == 15, man0, man_active0, tx_ready0, half_phase0);
            tick();
        end
        check("np end man", {31'd0, man0}, 32'd0);
        check("np end act", {31'd0, man_active0}, 32'd0);

        // Asynchronous reset mid-frame while Man is high
        tx_data = 8'h00;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("mid pre man", {31'd0, man}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid rst man", {31'd0, man}, 32'd0);
        check("mid rst act", {31'd0, man_active}, 32'd0);
        check("mid rst rdy", {31'd0, tx_ready}, 32'd0);
        #2;
        rst_n = 1'b1;
        #1;
        check("mid rel rdy", {31'd0, tx_ready}, 32'd0);
        tick();
        chk_idle("mid rel");
        tick();
        chk_idle("mid rel2");

        // Loopback decode of random words
        for (int f = 0; f < 100; f++) begin
            word = 8'($urandom);
            check($sformatf("lb rdy f%0d", f), {31'd0, tx_ready}, 32'd1);
            tx_data = word;
            tx_valid = 1'b1;
            tick();
            tx_valid = 1'b0;
            bad_pair = 1'b0;
            pre_dec = '0;
            data_dec = '0;
            first_half = 1'b0;
            for (int i = 0; i < 24; i++) begin
                if (i % 2 == 0) begin
                    first_half = man;
                    if (i < 8) pre_dec = {pre_dec[2:0], man};
                    else data_dec = {data_dec[6:0], man};
                end else if (man == first_half) begin
                    bad_pair = 1'b1;
                end
                if (!man_active) bad_pair = 1'b1;
                tick();
            end
            check($sformatf("lb pair f%0d", f), {31'd0, bad_pair}, 32'd0);
            check($sformatf("lb pre f%0d", f), {28'd0, pre_dec}, 32'hA);
            check($sformatf("lb data f%0d", f), {24'd0, data_dec}, {24'd0, word});
        end
        chk_idle("lb");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
